// File: rtl/delay_pkg.sv
// delay_pkg: shared types and constants for the delay path.
//   DELAY_WIDTH        tick/duration width, shared with the register file timer
//   DELAY_CLK_PER_TICK default clk cycles per tick (1 ms at 50 MHz)
//   delay_state_e      controller FSM states
package delay_pkg;
  localparam int unsigned DELAY_WIDTH        = 32;
  localparam int unsigned DELAY_CLK_PER_TICK = 50000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } delay_state_e;
endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: free-running clk divider plus the software-visible tick count.
// Ports:
//   clk    in   system clock
//   reset  in   async active-low reset
//   tick   out  high in the last cycle of each CLK_PER_TICK period
//   now    out  tick count, wraps at 2^WIDTH
module tick_prescaler
  import delay_pkg::*;
#(
  parameter int unsigned CLK_PER_TICK = DELAY_CLK_PER_TICK,
  parameter int unsigned WIDTH        = DELAY_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  output logic             tick,
  output logic [WIDTH-1:0] now
);
  localparam int unsigned    CW   = (CLK_PER_TICK > 1) ? $clog2(CLK_PER_TICK) : 1;
  localparam logic [CW-1:0]  LAST = CW'(CLK_PER_TICK - 1);

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] now_q, now_d;

  assign tick = (cnt_q == LAST);
  assign now  = now_q;

  // Phase is never disturbed by start, so wait length depends on when start lands.
  always_comb begin
    cnt_d = tick ? '0 : cnt_q + CW'(1);
    now_d = tick ? now_q + WIDTH'(1) : now_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      now_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      now_q <= now_d;
    end
  end
endmodule

// File: rtl/delay_controller.sv
// delay_controller: turns a "sleep N ticks" request into a busy window ending
// in a one-cycle done pulse; also exports the free-running tick count.
// Optional feature: define DELAY_CANCEL_EN to add the cancel input.
// Ports:
//   clk        in   system clock
//   reset      in   async active-low reset
//   start      in   one-cycle request, accepted only in IDLE
//   duration   in   ticks to wait, sampled with start
//   cancel     in   abort a running wait (DELAY_CANCEL_EN only)
//   busy       out  high while waiting
//   done       out  one-cycle completion pulse
//   now        out  free-running tick count
//   remaining  out  ticks left in the current wait, 0 when idle
module delay_controller
  import delay_pkg::*;
#(
  parameter int unsigned CLK_PER_TICK = DELAY_CLK_PER_TICK,
  parameter int unsigned WIDTH        = DELAY_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] duration,
`ifdef DELAY_CANCEL_EN
  input  logic             cancel,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] now,
  output logic [WIDTH-1:0] remaining
);
  delay_state_e     state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             tick;
  logic             abort;

`ifdef DELAY_CANCEL_EN
  assign abort = cancel;
`else
  assign abort = 1'b0;
`endif

  tick_prescaler #(
    .CLK_PER_TICK (CLK_PER_TICK),
    .WIDTH        (WIDTH)
  ) u_presc (
    .clk   (clk),
    .reset (reset),
    .tick  (tick),
    .now   (now)
  );

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    unique case (state_q)
      ST_IDLE: begin
        // cancel outranks start in IDLE: a simultaneous start is dropped
        if (start && !abort) begin
          if (duration == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_WAIT;
            rem_d   = duration;
          end
        end
      end
      ST_WAIT: begin
        if (abort) begin
          state_d = ST_IDLE;
          rem_d   = '0;
        end else if (tick) begin
          // rem_q >= 1 throughout WAIT, so this never underflows
          rem_d = rem_q - WIDTH'(1);
          if (rem_q == WIDTH'(1)) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: begin
        state_d = ST_IDLE;
        rem_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

  assign busy      = (state_q == ST_WAIT);
  assign done      = (state_q == ST_DONE);
  assign remaining = rem_q;
endmodule

// File: tb/tb_delay_controller.sv
// tb_delay_controller: randomized + directed bench for delay_controller with
// CLK_PER_TICK=4, WIDTH=4 (now wraps every 64 edges). The reference model
// describes each wait by its start edge s, length N and completion edge T,
// with edges counted from reset release; ticks are the edges that are
// multiples of CLK_PER_TICK.
module tb_delay_controller;
  localparam int CPT = 4;
  localparam int W   = 4;
`ifdef DELAY_CANCEL_EN
  localparam bit CANCEL_ON = 1'b1;
`else
  localparam bit CANCEL_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] duration;
  logic         cancel;
  logic         busy, done;
  logic [W-1:0] now, remaining;

  always #5 clk = ~clk;

  delay_controller #(.CLK_PER_TICK(CPT), .WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .duration  (duration),
`ifdef DELAY_CANCEL_EN
    .cancel    (cancel),
`endif
    .busy      (busy),
    .done      (done),
    .now       (now),
    .remaining (remaining)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // model: edge counter and current/last wait (s, N, T)
  int ecnt = 0;
  int m_s  = -2;
  int m_n  = 0;
  int m_t  = -2;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, ecnt);
    end
  endtask

  task automatic check_outputs();
    int  e;
    bit  eb, ed;
    int  er, en;
    e  = ecnt;
    en = (e / CPT) % (1 << W);
    eb = (e >= m_s) && (e < m_t);
    ed = (e == m_t);
    er = eb ? m_n - (e / CPT - m_s / CPT) : 0;
    chk("now", 32'(now), 32'(en));
    chk("busy", 32'(busy), 32'(eb));
    chk("done", 32'(done), 32'(ed));
    chk("remaining", 32'(remaining), 32'(er));
  endtask

  // drive one cycle's inputs, update the model for the coming edge, check after it
  task automatic step(input bit st, input logic [W-1:0] d, input bit cn);
    int e;
    e        = ecnt + 1;
    start    = st;
    duration = d;
    cancel   = cn & CANCEL_ON;
    if (CANCEL_ON && cn) begin
      if ((e - 1 >= m_s) && (e - 1 < m_t)) m_t = e - 2;
    end else if (st && e >= m_t + 2) begin
      m_s = e;
      m_n = int'(d);
      m_t = (d == '0) ? e : (e / CPT + int'(d)) * CPT;
    end
    @(posedge clk);
    ecnt = e;
    @(negedge clk);
    start  = 1'b0;
    cancel = 1'b0;
    check_outputs();
  endtask

  // assert reset at a negedge, check async clear, release one cycle later
  task automatic do_reset();
    reset = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_now", 32'(now), 32'd0);
    chk("rst_rem", 32'(remaining), 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    ecnt  = 0;
    m_s   = -2;
    m_t   = -2;
    m_n   = 0;
    check_outputs();
  endtask

  initial begin
    int lat, s0, dcnt;
    reset = 1'b1; start = 1'b0; duration = '0; cancel = 1'b0;
    @(negedge clk);
    do_reset();

    // idle after reset: now == 2 after 8 edges
    for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b0);
    chk("now_after_8", 32'(now), 32'd2);

    // zero-length wait
    step(1'b1, 4'd0, 1'b0);
    step(1'b0, '0, 1'b0);

    // duration 3 with starts hammered during WAIT; measure latency and pulses
    step(1'b0, '0, 1'b0);
    step(1'b1, 4'd3, 1'b0);
    s0 = ecnt; lat = 999; dcnt = 0;
    for (int i = 0; i < 30; i++) begin
      if (done) begin lat = ecnt - s0; dcnt++; break; end
      step(i[0], 4'd7, 1'b0);
    end
    chk("lat_in_range", 32'(lat >= 9 && lat <= 12), 32'd1);
    step(1'b1, 4'd7, 1'b0);  // lands in DONE: ignored
    if (done) dcnt++;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, '0, 1'b0);
      if (done) dcnt++;
    end
    chk("done_pulses", 32'(dcnt), 32'd1);

    // max duration across the now wrap
    step(1'b1, 4'd15, 1'b0);
    for (int i = 0; i < 70; i++) step(1'b0, '0, 1'b0);

    // reset mid-wait
    step(1'b1, 4'd5, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b0);
    @(negedge clk);
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b0);

    // cancel mid-wait, then cancel+start in IDLE
    if (CANCEL_ON) begin
      step(1'b1, 4'd5, 1'b0);
      for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b0);
      step(1'b0, '0, 1'b1);
      chk("cancel_busy", 32'(busy), 32'd0);
      chk("cancel_rem", 32'(remaining), 32'd0);
      for (int i = 0; i < 25; i++) step(1'b0, '0, 1'b0);
      step(1'b1, 4'd2, 1'b1);
      for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b0);
    end

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bit          st, cn;
      logic [W-1:0] d;
      st = ($urandom_range(0, 3) == 0);
      d  = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 15)) : W'($urandom_range(0, 3));
      cn = ($urandom_range(0, 39) == 0);
      step(st, d, cn);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
